// File: rtl/dla_pkg.sv
// Shared encodings for the DLA PE sequencer and datapath: job modes and sequencer states.
package dla_pkg;

   typedef enum logic [1:0] {
      ModeCv  = 2'd0,
      ModeDw  = 2'd1,
      ModePw  = 2'd2,
      ModeGap = 2'd3
   } pe_mode_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StOut
   } seq_state_e;

   // Only depthwise and pointwise jobs are handled by this sequencer.
   function automatic logic mode_supported(input logic [1:0] m);
      return (m == ModeDw) || (m == ModePw);
   endfunction

endpackage

// File: rtl/pe_acc.sv
// Tag-driven accumulator: delays issue/first/last tags to line up with PE products,
// accumulates them and captures the finished sum in a result register.
module pe_acc #(
   parameter int unsigned ACC_W = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue,
   input  logic                    first,
   input  logic                    last,
   input  logic signed [15:0]      product,
   output logic                    last_arrived,
   output logic signed [ACC_W-1:0] res_data
);

   logic [1:0]              vld_q;
   logic [1:0]              fst_q;
   logic [1:0]              lst_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] prod_ext;

   always_comb begin
      prod_ext = ACC_W'(product);
      acc_d    = fst_q[1] ? prod_ext : acc_q + prod_ext;
   end

   assign last_arrived = vld_q[1] & lst_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q    <= '0;
         fst_q    <= '0;
         lst_q    <= '0;
         acc_q    <= '0;
         res_data <= '0;
      end else begin
         vld_q <= {vld_q[0], issue};
         fst_q <= {fst_q[0], issue & first};
         lst_q <= {lst_q[0], issue & last};
         if (vld_q[1]) acc_q <= acc_d;
         // Result register only moves on the closing term, so it holds through OUT.
         if (last_arrived) res_data <= acc_d;
      end
   end

endmodule

// File: rtl/pe_seq_ctrl.sv
// PE job sequencer: issues pixel/weight read pairs per output term, waits for the
// accumulated result and hands it out over a valid/ready interface.
module pe_seq_ctrl
   import dla_pkg::*;
#(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned ACC_W  = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              mode,
   input  logic [LEN_W-1:0]        cfg_len,
   input  logic [LEN_W-1:0]        cfg_cnt,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [1:0]              pe_mode,
   output logic                    pix_rd_en,
   output logic [ADDR_W-1:0]       pix_addr,
   output logic                    wgt_rd_en,
   output logic [ADDR_W-1:0]       wgt_addr,
   input  logic signed [15:0]      product,
   output logic                    res_valid,
   output logic signed [ACC_W-1:0] res_data,
   input  logic                    res_ready
);

   seq_state_e       state_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] cnt_q;
   logic [LEN_W-1:0] t_q;
   logic [LEN_W-1:0] o_q;
   logic             first_q;
   logic             last_q;
   logic             last_arrived;
   logic [LEN_W-1:0] len_m1;
   logic [LEN_W-1:0] cnt_m1;
   logic [LEN_W-1:0] t_inc;

   assign len_m1 = len_q - LEN_W'(1);
   assign cnt_m1 = cnt_q - LEN_W'(1);
   assign t_inc  = t_q + LEN_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         cnt_q     <= '0;
         t_q       <= '0;
         o_q       <= '0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         pe_mode   <= ModeCv;
         pix_rd_en <= 1'b0;
         wgt_rd_en <= 1'b0;
         pix_addr  <= '0;
         wgt_addr  <= '0;
         res_valid <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (mode_supported(mode) && cfg_len != '0 && cfg_cnt != '0) begin
                     state_q   <= StIssue;
                     busy      <= 1'b1;
                     pe_mode   <= mode;
                     len_q     <= cfg_len;
                     cnt_q     <= cfg_cnt;
                     t_q       <= '0;
                     o_q       <= '0;
                     pix_rd_en <= 1'b1;
                     wgt_rd_en <= 1'b1;
                     pix_addr  <= '0;
                     wgt_addr  <= '0;
                     first_q   <= 1'b1;
                     last_q    <= (cfg_len == LEN_W'(1));
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            StIssue: begin
               if (t_q == len_m1) begin
                  state_q   <= StDrain;
                  pix_rd_en <= 1'b0;
                  wgt_rd_en <= 1'b0;
                  first_q   <= 1'b0;
                  last_q    <= 1'b0;
               end else begin
                  t_q      <= t_inc;
                  pix_addr <= pix_addr + ADDR_W'(1);
                  wgt_addr <= (pe_mode == ModePw) ? ADDR_W'(t_inc) : wgt_addr + ADDR_W'(1);
                  first_q  <= 1'b0;
                  last_q   <= (t_inc == len_m1);
               end
            end
            StDrain: begin
               if (last_arrived) begin
                  state_q   <= StOut;
                  res_valid <= 1'b1;
               end
            end
            StOut: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  if (o_q == cnt_m1) begin
                     state_q <= StIdle;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     // Pixel and DW weight counters keep running across outputs.
                     state_q   <= StIssue;
                     o_q       <= o_q + LEN_W'(1);
                     t_q       <= '0;
                     pix_rd_en <= 1'b1;
                     wgt_rd_en <= 1'b1;
                     pix_addr  <= pix_addr + ADDR_W'(1);
                     wgt_addr  <= (pe_mode == ModePw) ? '0 : wgt_addr + ADDR_W'(1);
                     first_q   <= 1'b1;
                     last_q    <= (len_q == LEN_W'(1));
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   pe_acc #(
      .ACC_W(ACC_W)
   ) u_acc (
      .clk         (clk),
      .rst         (rst),
      .issue       (pix_rd_en),
      .first       (first_q),
      .last        (last_q),
      .product     (product),
      .last_arrived(last_arrived),
      .res_data    (res_data)
   );

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Self-checking bench for pe_seq_ctrl: directed and random jobs against a sum-of-products model.
module tb_pe_seq_ctrl;
   import dla_pkg::*;

   localparam int AW = 6;
   localparam int LW = 8;
   localparam int CW = 24;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [1:0]           mode;
   logic [LW-1:0]        cfg_len;
   logic [LW-1:0]        cfg_cnt;
   logic                 busy, done, err;
   logic [1:0]           pe_mode;
   logic                 pix_rd_en, wgt_rd_en;
   logic [AW-1:0]        pix_addr, wgt_addr;
   logic signed [15:0]   product;
   logic                 res_valid;
   logic signed [CW-1:0] res_data;
   logic                 res_ready;

   int total = 0;
   int bad   = 0;

   int                   job_prods[$];
   int                   pq[$];
   int                   pix_log[$];
   int                   wgt_log[$];
   logic signed [CW-1:0] res_log[$];
   int                   done_cnt = 0;
   int                   err_cnt  = 0;
   logic signed [15:0]   s0, s1;

   always #5 clk = ~clk;

   pe_seq_ctrl #(
      .ADDR_W(AW),
      .LEN_W (LW),
      .ACC_W (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .mode     (mode),
      .cfg_len  (cfg_len),
      .cfg_cnt  (cfg_cnt),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .pe_mode  (pe_mode),
      .pix_rd_en(pix_rd_en),
      .pix_addr (pix_addr),
      .wgt_rd_en(wgt_rd_en),
      .wgt_addr (wgt_addr),
      .product  (product),
      .res_valid(res_valid),
      .res_data (res_data),
      .res_ready(res_ready)
   );

   // PE model and monitor: a read seen mid-cycle k presents its product over the edge ending k+2.
   always @(negedge clk) begin
      if (pix_rd_en) begin
         pix_log.push_back(int'(pix_addr));
         wgt_log.push_back(int'(wgt_addr));
         s0 <= (pq.size() > 0) ? 16'(pq.pop_front()) : 16'sd0;
      end else begin
         s0 <= 'x;
      end
      s1      <= s0;
      product <= s1;
      if (res_valid && res_ready) res_log.push_back(res_data);
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [1:0] m, input int l, input int c);
      @(negedge clk);
      mode    = m;
      cfg_len = LW'(l);
      cfg_cnt = LW'(c);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_pq();
      pq.delete();
      foreach (job_prods[i]) pq.push_back(job_prods[i]);
   endtask

   task automatic wait_done(input string tag);
      bit fin = 1'b0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         @(negedge clk);
         if (done) fin = 1'b1;
      end
      check({tag, "_done_seen"}, fin, 1);
   endtask

   // Compare logged addresses/results from index bases against the job's arithmetic model.
   task automatic check_job(input string tag, input logic [1:0] m, input int len, input int cnt,
                            input int pix0, input int res0);
      logic signed [CW-1:0] a;
      int n = len * cnt;
      check({tag, "_nreads"}, pix_log.size() - pix0, n);
      check({tag, "_nres"}, res_log.size() - res0, cnt);
      for (int i = 0; i < n && pix0 + i < pix_log.size(); i++) begin
         check($sformatf("%s_pix%0d", tag, i), pix_log[pix0+i], i % (1 << AW));
         check($sformatf("%s_wgt%0d", tag, i), wgt_log[pix0+i],
               (m == ModePw) ? (i % len) % (1 << AW) : i % (1 << AW));
      end
      for (int o = 0; o < cnt && res0 + o < res_log.size(); o++) begin
         a = '0;
         for (int t = 0; t < len; t++) a = a + CW'(job_prods[o*len+t]);
         check($sformatf("%s_res%0d", tag, o), res_log[res0+o], a);
      end
   endtask

   task automatic run_job(input string tag, input logic [1:0] m, input int len, input int cnt,
                          input bit stall, input bit poke);
      int pix0, res0, done0, err0;
      bit fin = 1'b0;
      pix0  = pix_log.size();
      res0  = res_log.size();
      done0 = done_cnt;
      err0  = err_cnt;
      load_pq();
      do_start(m, len, cnt);
      check({tag, "_busy_on"}, busy, 1);
      check({tag, "_pe_mode"}, pe_mode, m);
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         res_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (poke && cyc == 4) begin
            start   = 1'b1;
            mode    = (m == ModePw) ? ModeDw : ModePw;
            cfg_len = LW'(len + 3);
            cfg_cnt = LW'(cnt + 1);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) fin = 1'b1;
      end
      start     = 1'b0;
      res_ready = 1'b1;
      check({tag, "_done_seen"}, fin, 1);
      check({tag, "_busy_off"}, busy, 0);
      if (poke) check({tag, "_pe_mode_held"}, pe_mode, m);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_done_count"}, done_cnt - done0, 1);
      check({tag, "_no_err"}, err_cnt - err0, 0);
      check_job(tag, m, len, cnt, pix0, res0);
   endtask

   task automatic reject(input string tag, input logic [1:0] m, input int l, input int c);
      int pix0 = pix_log.size();
      do_start(m, l, c);
      check({tag, "_err"}, err, 1);
      check({tag, "_busy"}, busy, 0);
      @(negedge clk);
      check({tag, "_err_end"}, err, 0);
      check({tag, "_noread"}, pix_log.size() - pix0, 0);
   endtask

   initial begin
      int pix_n, res0, done0, len, cnt;
      bit seen;
      logic [1:0] m;

      rst       = 1'b1;
      start     = 1'b0;
      mode      = '0;
      cfg_len   = '0;
      cfg_cnt   = '0;
      res_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_rd", {pix_rd_en, wgt_rd_en, res_valid, done, err}, 0);
      check("rst_addr", {pix_addr, wgt_addr}, 0);
      check("rst_data", res_data, 0);
      rst = 1'b0;

      job_prods = '{1, 2, 3, 4, 5, 6};
      run_job("pw32", ModePw, 3, 2, 1'b0, 1'b0);

      job_prods = '{-3, 1, 127, 127};
      run_job("dw22", ModeDw, 2, 2, 1'b0, 1'b0);

      reject("rej_cv", ModeCv, 3, 2);
      reject("rej_gap", ModeGap, 3, 2);
      reject("rej_len0", ModePw, 0, 2);
      reject("rej_cnt0", ModeDw, 2, 0);

      // Back-pressure: result held for five cycles with no reads.
      job_prods = '{10, -20, 30, 40};
      load_pq();
      res0      = res_log.size();
      res_ready = 1'b0;
      do_start(ModePw, 2, 2);
      seen = 1'b0;
      for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
         @(negedge clk);
         if (res_valid) seen = 1'b1;
      end
      check("hold_valid_seen", seen, 1);
      pix_n = pix_log.size();
      repeat (5) begin
         @(negedge clk);
         check("hold_valid", res_valid, 1);
         check("hold_data", res_data, -10);
         check("hold_noread", pix_rd_en, 0);
      end
      check("hold_nreads", pix_log.size() - pix_n, 0);
      res_ready = 1'b1;
      wait_done("hold");
      @(negedge clk);
      check_job("hold", ModePw, 2, 2, pix_n - 2, res0);

      // Reset in the middle of the second output's issue phase.
      job_prods = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
      load_pq();
      done0 = done_cnt;
      do_start(ModePw, 4, 3);
      seen = 1'b0;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
         @(negedge clk);
         if (pix_rd_en && pix_addr == AW'(5)) seen = 1'b1;
      end
      check("abort_reached", seen, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_flags", {pix_rd_en, wgt_rd_en, res_valid, done, err}, 0);
      check("abort_addr", {pix_addr, wgt_addr}, 0);
      check("abort_data", res_data, 0);
      check("abort_mode", pe_mode, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_done", done_cnt - done0, 0);
      job_prods = '{7, -8, 9, 100};
      run_job("after_abort", ModePw, 2, 2, 1'b0, 1'b0);

      job_prods = '{5, 6, 7, 8, 9, 10};
      run_job("poke", ModePw, 3, 2, 1'b0, 1'b1);
      job_prods = '{-1234};
      run_job("single", ModeDw, 1, 1, 1'b0, 1'b1);

      // Address wrap: 80 reads with 6-bit addresses.
      job_prods.delete();
      for (int i = 0; i < 80; i++) job_prods.push_back(int'($urandom_range(0, 65535)) - 32768);
      run_job("wrap", ModeDw, 20, 4, 1'b1, 1'b0);

      for (int j = 0; j < 6; j++) begin
         len = int'($urandom_range(1, 20));
         cnt = int'($urandom_range(1, 6));
         m   = ($urandom_range(0, 1) == 0) ? ModeDw : ModePw;
         job_prods.delete();
         for (int i = 0; i < len * cnt; i++)
            job_prods.push_back(int'($urandom_range(0, 65535)) - 32768);
         run_job($sformatf("rnd%0d", j), m, len, cnt, 1'(j % 2), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_seq_ctrl.md
PE_SEQ_CTRL -- requirements
Module: pe_seq_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, width of pixel and weight buffer addresses.
REQ-002 Parameter LEN_W, default 8, width of term-count and output-count fields.
REQ-003 Parameter ACC_W, default 24, width of the signed accumulator and result.
REQ-004 clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  single-cycle job request; sampled only in IDLE.
REQ-007 mode  in  2  job mode: 0 CV, 1 DW, 2 PW, 3 GAP.
REQ-008 cfg_len  in  LEN_W  products per output (1..2^LEN_W-1).
REQ-009 cfg_cnt  in  LEN_W  outputs per job (1..2^LEN_W-1).
REQ-010 busy  out  1  high from start acceptance until the job's last result handshake.
REQ-011 done  out  1  one-cycle pulse after the last result handshake.
REQ-012 err  out  1  one-cycle pulse on rejected start.
REQ-013 pe_mode  out  2  latched job mode, drives the PE mode input.
REQ-014 pix_rd_en / pix_addr  out  1 / ADDR_W  pixel buffer read; data returns 1 cycle later.
REQ-015 wgt_rd_en / wgt_addr  out  1 / ADDR_W  weight buffer read; data returns 1 cycle later.
REQ-016 product  in  16 signed  PE product, valid 2 cycles after the matching read issue.
REQ-017 res_valid / res_data / res_ready  out / out ACC_W signed / in  result valid-ready handshake.

Function
REQ-018 States: IDLE, ISSUE, DRAIN, OUT.
REQ-019 IDLE: start with mode DW or PW, cfg_len != 0 and cfg_cnt != 0 latches mode/cfg, clears counters, goes to ISSUE next cycle; busy rises the same edge.
REQ-020 IDLE: start with mode CV or GAP, or with a zero field, pulses err the next cycle and stays IDLE.
REQ-021 ISSUE: one read pair per cycle (pix_rd_en = wgt_rd_en = 1); term counter t counts 0..cfg_len-1; output counter o counts 0..cfg_cnt-1.
REQ-022 pix_addr = running pixel counter, starting at 0 and incremented per issue; not reset between outputs.
REQ-023 wgt_addr: PW = t; DW = running weight counter, 0..cfg_len*cfg_cnt-1.
REQ-024 Address counters wrap modulo 2^ADDR_W without error.
REQ-025 ISSUE with t = cfg_len-1 goes to DRAIN; read enables deassert in DRAIN.
REQ-026 A 2-stage valid shift register carries issue/first/last tags aligned with product arrival.
REQ-027 Aligned first tag loads acc with sign-extended product; other valid tags add it; no saturation, ACC_W wrap.
REQ-028 DRAIN lasts until the last tag arrives (2 cycles), then goes to OUT with res_valid = 1 and res_data = acc.
REQ-029 res_data stays stable while res_valid && !res_ready.
REQ-030 OUT: on res_valid && res_ready, if o = cfg_cnt-1, go to IDLE, drop busy, pulse done; else o++, t = 0, go to ISSUE.
REQ-031 start while busy is ignored (no err, no relatch).
REQ-032 mode changes while busy have no effect; pe_mode holds the latched value until the next accepted start.

Reset
REQ-033 On rst: state IDLE; busy, done, err, pix_rd_en, wgt_rd_en, res_valid = 0.
REQ-034 On rst: pix_addr, wgt_addr, res_data, acc, counters, tags = 0; pe_mode = 0.
REQ-035 rst mid-job aborts immediately; no done pulse; the next start begins a fresh job.

Structure
REQ-036 Mode encodings (CV/DW/PW/GAP) and the state enum go in shared package dla_pkg; the PE datapath uses the same mode constants.
REQ-037 One natural sub-module: pe_acc (tag-driven accumulator with result register); the FSM and counters stay in pe_seq_ctrl.

Verification
REQ-038 PW, cfg_len=3, cfg_cnt=2, products 1,2,3,4,5,6, res_ready=1 -> res_data 6 then 15; wgt_addr 0,1,2,0,1,2; pix_addr 0..5; done once.
REQ-039 DW, cfg_len=2, cfg_cnt=2 -> wgt_addr 0,1,2,3; products -3,1,127,127 -> res_data -2 then 254.
REQ-040 start with mode CV -> err pulse 1 cycle, busy stays 0, no reads; the same check applies to GAP and to cfg_len=0.
REQ-041 res_ready low for 5 cycles in OUT -> res_valid and res_data held; no reads issued; resumes after handshake.
REQ-042 rst asserted during ISSUE of output 1 of 3 -> all outputs 0 asynchronously; the next PW job starts at pix_addr 0.
REQ-043 start pulsed while busy -> ignored; the job completes with the original cfg; cfg_len=1, cfg_cnt=1 job gives res_data = the single product.
